// File: rtl/pipelined_cla_adder_pkg.sv
//==============================================================================
// Module      : pipelined_cla_adder_pkg
// Description : Shared constants for the pipelined carry-lookahead adder:
//               default operand width, bits per pipeline stage and the
//               derivation of the pipeline depth.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package pipelined_cla_adder_pkg;

    // Default operand/sum width in bits
    localparam int c_CLA_WIDTH = 16;

    // Default number of bits added by one pipeline stage
    localparam int c_CLA_SEG   = 4;

    // Pipeline depth: one stage per segment. WIDTH must be a multiple of SEG
    // and span at least two segments.
    function automatic int cla_stages(input int width, input int seg);
        return width / seg;
    endfunction

    localparam int c_CLA_STAGES = cla_stages(c_CLA_WIDTH, c_CLA_SEG);

endpackage : pipelined_cla_adder_pkg

`default_nettype wire

// File: rtl/pipelined_cla_adder_cla_segment.sv
//==============================================================================
// Module      : cla_segment
// Description : SEG-bit carry-lookahead adder slice. Every carry is formed
//               directly from generate/propagate terms and the slice carry-in,
//               so no carry ripples bit to bit. Also exports the carry into
//               the slice MSB, which the top slice uses for overflow.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cla_segment
    import pipelined_cla_adder_pkg::*;
#(
    parameter int SEG = c_CLA_SEG
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           c_in,
    output logic [SEG-1:0] s,
    output logic           c_out,
    output logic           c_msb_in
);

    logic [SEG-1:0] w_p;
    logic [SEG-1:0] w_g;
    logic [SEG:0]   w_c;

    assign w_p = a ^ b;
    assign w_g = a & b;

    // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c_in
    always_comb begin
        logic w_term;
        w_term = 1'b1;
        w_c    = '0;
        w_c[0] = c_in;
        for (int i = 0; i < SEG; i++) begin
            w_term     = 1'b1;
            w_c[i + 1] = 1'b0;
            for (int j = i; j >= 0; j--) begin
                w_c[i + 1] = w_c[i + 1] | (w_term & w_g[j]);
                w_term     = w_term & w_p[j];
            end
            w_c[i + 1] = w_c[i + 1] | (w_term & c_in);
        end
    end

    assign s        = w_p ^ w_c[SEG-1:0];
    assign c_out    = w_c[SEG];
    assign c_msb_in = w_c[SEG-1];

endmodule : cla_segment

`default_nettype wire

// File: rtl/pipelined_cla_adder.sv
//==============================================================================
// Module      : pipelined_cla_adder
// Description : WIDTH-bit add/subtract unit built as a STAGES-deep pipeline,
//               one SEG-bit carry-lookahead slice per stage. Operands that a
//               stage has not consumed yet travel with the transaction
//               (input skewing) together with the partial sum and the sub
//               flag. Valid/ready handshake on both sides; a result held at
//               the output freezes the whole pipeline. Latency is STAGES
//               rising edges counting the accepting edge.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pipelined_cla_adder
    import pipelined_cla_adder_pkg::*;
#(
    parameter int WIDTH = c_CLA_WIDTH,
    parameter int SEG   = c_CLA_SEG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int c_STAGES = cla_stages(WIDTH, SEG);

    // Stage registers: stage k holds the sum through segment k and its carry
    logic [c_STAGES-1:0] r_vld;
    logic [c_STAGES-1:0] r_c;
    logic [WIDTH-1:0]    r_sum [c_STAGES];
    logic                r_ovf;

    // Operands and mode travelling along with the transaction; the last
    // stage has no later consumer, so these stop one stage short
    logic [WIDTH-1:0]    r_a   [c_STAGES-1];
    logic [WIDTH-1:0]    r_b   [c_STAGES-1];
    logic [c_STAGES-2:0] r_sub;

    // Per-stage combinational next values
    logic [SEG-1:0]      w_a_seg   [c_STAGES];
    logic [SEG-1:0]      w_b_seg   [c_STAGES];
    logic [SEG-1:0]      w_s       [c_STAGES];
    logic [WIDTH-1:0]    w_sum_nxt [c_STAGES];
    logic [c_STAGES-1:0] w_cin;
    logic [c_STAGES-1:0] w_cout;
    logic [c_STAGES-1:0] w_vld_nxt;
    logic [WIDTH-1:0]    w_a_nxt   [c_STAGES-1];
    logic [WIDTH-1:0]    w_b_nxt   [c_STAGES-1];
    logic [c_STAGES-2:0] w_sub_nxt;
    logic                w_cmsb_last;
    logic                w_stall;

    // A result waiting on the consumer freezes every stage
    assign w_stall  = r_vld[c_STAGES-1] & ~out_ready;
    assign in_ready = ~w_stall;

    for (genvar k = 0; k < c_STAGES; k++) begin : g_stage
        localparam logic [WIDTH-1:0] c_SEG_MASK =
            {{(WIDTH-SEG){1'b0}}, {SEG{1'b1}}} << (k * SEG);

        if (k == 0) begin : g_head
            // Subtraction is A + ~B + 1: invert B and force the carry-in
            assign w_a_seg[k]   = in1[SEG-1:0];
            assign w_b_seg[k]   = in2[SEG-1:0] ^ {SEG{sub}};
            assign w_cin[k]     = sub | cin;
            assign w_vld_nxt[k] = in_valid;
            assign w_sum_nxt[k] = WIDTH'(w_s[k]);
        end else begin : g_body
            assign w_a_seg[k]   = r_a[k-1][k*SEG +: SEG];
            assign w_b_seg[k]   = r_b[k-1][k*SEG +: SEG] ^ {SEG{r_sub[k-1]}};
            assign w_cin[k]     = r_c[k-1];
            assign w_vld_nxt[k] = r_vld[k-1];
            assign w_sum_nxt[k] = (r_sum[k-1] & ~c_SEG_MASK)
                                | (WIDTH'(w_s[k]) << (k * SEG));
        end

        if (k < c_STAGES - 1) begin : g_fwd
            if (k == 0) begin : g_fwd_head
                assign w_a_nxt[k]   = in1;
                assign w_b_nxt[k]   = in2;
                assign w_sub_nxt[k] = sub;
            end else begin : g_fwd_body
                assign w_a_nxt[k]   = r_a[k-1];
                assign w_b_nxt[k]   = r_b[k-1];
                assign w_sub_nxt[k] = r_sub[k-1];
            end
        end

        // Only the top slice's MSB carry-in matters (overflow detection)
        if (k == c_STAGES - 1) begin : g_tail
            cla_segment #(.SEG(SEG)) u_seg (
                .a        (w_a_seg[k]),
                .b        (w_b_seg[k]),
                .c_in     (w_cin[k]),
                .s        (w_s[k]),
                .c_out    (w_cout[k]),
                .c_msb_in (w_cmsb_last)
            );
        end else begin : g_inner
            logic w_cmsb_unused;
            cla_segment #(.SEG(SEG)) u_seg (
                .a        (w_a_seg[k]),
                .b        (w_b_seg[k]),
                .c_in     (w_cin[k]),
                .s        (w_s[k]),
                .c_out    (w_cout[k]),
                .c_msb_in (w_cmsb_unused)
            );
        end
    end

    // Advance all stages together; bubbles move through as invalid stages
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld <= '0;
            r_c   <= '0;
            r_sub <= '0;
            r_ovf <= 1'b0;
            for (int k = 0; k < c_STAGES; k++) begin
                r_sum[k] <= '0;
            end
            for (int k = 0; k < c_STAGES - 1; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
            end
        end else if (!w_stall) begin
            r_vld <= w_vld_nxt;
            r_c   <= w_cout;
            r_sub <= w_sub_nxt;
            r_ovf <= w_cmsb_last ^ w_cout[c_STAGES-1];
            for (int k = 0; k < c_STAGES; k++) begin
                r_sum[k] <= w_sum_nxt[k];
            end
            for (int k = 0; k < c_STAGES - 1; k++) begin
                r_a[k] <= w_a_nxt[k];
                r_b[k] <= w_b_nxt[k];
            end
        end
    end

    assign out_valid = r_vld[c_STAGES-1];
    assign sum       = r_sum[c_STAGES-1];
    assign cout      = r_c[c_STAGES-1];
    assign ovf       = r_ovf;

endmodule : pipelined_cla_adder

`default_nettype wire

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/sum width in bits.
REQ-002 SHALL have parameter SEG, default 4, bits added per pipeline stage; WIDTH SHALL be a multiple of SEG; STAGES = WIDTH/SEG.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 SHALL have port in_valid  input  1  operand set presented.
REQ-006 SHALL have port in_ready  output  1  block can accept operands this cycle.
REQ-007 SHALL have port in1  input  WIDTH  operand A.
REQ-008 SHALL have port in2  input  WIDTH  operand B.
REQ-009 SHALL have port cin  input  1  carry-in (ignored in subtract mode).
REQ-010 SHALL have port sub  input  1  0 = A+B+cin, 1 = A-B (A + ~B + 1).
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-013 SHALL have port sum  output  WIDTH  result.
REQ-014 SHALL have port cout  output  1  carry out of MSB.
REQ-015 SHALL have port ovf  output  1  two's-complement overflow (carry into MSB XOR carry out).

Function
REQ-016 SHALL accept an operand set on a rising edge where in_valid && in_ready.
REQ-017 SHALL be a STAGES-deep pipeline; stage k adds segment k (bits k*SEG+SEG-1 : k*SEG) using registered carry from stage k-1; stage 0 carry = sub ? 1 : cin.
REQ-018 SHALL carry unprocessed operand segments, sub flag and completed sum segments forward with each stage (input skewing), so no stage sees operands of a different transaction.
REQ-019 SHALL present a result exactly STAGES rising edges after acceptance when never stalled (default: 4 cycles).
REQ-020 SHALL sustain one accepted transaction per cycle when out_ready is held 1.
REQ-021 SHALL stall the whole pipeline when out_valid && !out_ready; stall SHALL hold sum, cout, ovf, out_valid and every stage register unchanged.
REQ-022 SHALL drive in_ready = !(out_valid && !out_ready) combinationally; bubbles SHALL advance as invalid stages.
REQ-023 SHALL hold outputs stable while out_valid && !out_ready.
REQ-024 SHALL compute all arithmetic modulo 2^WIDTH; cout = bit WIDTH of the full sum; in subtract mode cout = 1 means no borrow.
REQ-025 SHALL produce results in acceptance order; no transaction dropped or duplicated.

Reset
REQ-026 SHALL on rst = 0 immediately clear all stage valid bits, stage data, sum, cout, ovf and out_valid to 0, independent of clk.
REQ-027 SHALL discard in-flight transactions on reset mid-operation; in_ready SHALL be 1 in the first cycle after rst returns to 1.
REQ-028 SHALL release reset synchronously to the first rising edge after deassertion (no acceptance in the deasserting cycle's edge ambiguity beyond normal setup).

Structure
REQ-029 SHALL place WIDTH/SEG defaults and the STAGES derivation in a shared package/header of adder constants.
REQ-030 SHALL instantiate one sub-module per stage, cla_segment (SEG-bit carry-lookahead add: a, b, c_in -> s, c_out, c_msb_in), generated STAGES times.

Verification
REQ-031 SHALL cover: in1=16'h1234, in2=16'h4321, cin=0, sub=0, out_ready=1 -> out_valid exactly 4 edges later, sum=16'h5555, cout=0, ovf=0.
REQ-032 SHALL cover: in1=16'hFFFF, in2=16'h0001, cin=0 -> sum=16'h0000, cout=1, ovf=0 (carry ripples through all stages).
REQ-033 SHALL cover: in1=16'h7FFF, in2=16'h0001, sub=0 -> sum=16'h8000, ovf=1; in1=16'h0005, in2=16'h0007, sub=1 -> sum=16'hFFFE, cout=0.
REQ-034 SHALL cover: 8 back-to-back transactions, out_ready=1 -> 8 consecutive out_valid cycles, in order; then out_ready=0 for 3 cycles with pipeline full -> in_ready=0, outputs frozen, no loss after release.
REQ-035 SHALL cover: rst=0 pulsed mid-cycle with 3 transactions in flight -> out_valid=0, sum=0 immediately, no stale result emerges afterwards.
REQ-036 SHALL cover: WIDTH=32, SEG=8 instance, 1000 random operands with random in_valid/out_ready -> every sum/cout/ovf matches reference model.
